// File: rtl/fsweep_pkg.sv
// Shared types and constants for the frequency sweep controller.
package fsweep_pkg;

  localparam int unsigned FREQ_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running sample-tick divider: one-clock tick every cfg_div+1 clocks.
module tick_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  // Period is re-sampled only at the wrap so a mid-period change never shortens a tick interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      period <= cfg_div;
      tick   <= 1'b0;
    end else if (cnt == period) begin
      cnt    <= '0;
      period <= cfg_div;
      tick   <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick   <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Stepped frequency sweep: dwells a set number of sample ticks per frequency word,
// stepping up or down toward a stop word with clamping, optionally looping.
module freq_sweep_ctrl
  import fsweep_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               cfg_loop,
  output logic [FREQ_W-1:0]  freq_word,
  output logic               sample_tick,
  output logic               busy,
  output logic               done
);

  state_t state, state_nxt;

  logic [FREQ_W-1:0]  freq_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt, dwell_inc;
  logic [FREQ_W-1:0]  start_q, stop_q, step_q;
  logic [FREQ_W-1:0]  start_nxt, stop_nxt, step_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic               loop_q, loop_nxt, up_q, up_nxt;
  logic [FREQ_W:0]    sum9, diff9;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .cfg_div (cfg_div),
    .tick    (sample_tick)
  );

  assign busy = (state == DWELL) || (state == STEP);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      freq_word <= '0;
      dwell_cnt <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      freq_word <= freq_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      start_q   <= start_nxt;
      stop_q    <= stop_nxt;
      step_q    <= step_nxt;
      dwell_q   <= dwell_nxt;
      loop_q    <= loop_nxt;
      up_q      <= up_nxt;
    end
  end

  // 9-bit arithmetic lets the clamp detect overflow/borrow instead of wrapping mod 256.
  assign sum9      = {1'b0, freq_word} + {1'b0, step_q};
  assign diff9     = {1'b0, freq_word} - {1'b0, step_q};
  assign dwell_inc = dwell_cnt + 1'b1;

  always_comb begin
    state_nxt     = state;
    freq_nxt      = freq_word;
    dwell_cnt_nxt = dwell_cnt;
    start_nxt     = start_q;
    stop_nxt      = stop_q;
    step_nxt      = step_q;
    dwell_nxt     = dwell_q;
    loop_nxt      = loop_q;
    up_nxt        = up_q;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          start_nxt     = cfg_start_freq;
          stop_nxt      = cfg_stop_freq;
          step_nxt      = (cfg_step == '0) ? FREQ_W'(1) : cfg_step;
          dwell_nxt     = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
          loop_nxt      = cfg_loop;
          up_nxt        = (cfg_stop_freq >= cfg_start_freq);
          freq_nxt      = cfg_start_freq;
          dwell_cnt_nxt = '0;
          state_nxt     = DWELL;
        end
      end
      DWELL: begin
        if (sample_tick) begin
          if (dwell_inc == dwell_q) begin
            dwell_cnt_nxt = '0;
            state_nxt     = STEP;
          end else begin
            dwell_cnt_nxt = dwell_inc;
          end
        end
      end
      STEP: begin
        if (freq_word == stop_q) begin
          if (loop_q) begin
            freq_nxt  = start_q;
            state_nxt = DWELL;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          if (up_q) begin
            freq_nxt = (sum9 > {1'b0, stop_q}) ? stop_q : sum9[FREQ_W-1:0];
          end else begin
            freq_nxt = (diff9[FREQ_W] || (diff9[FREQ_W-1:0] < stop_q)) ? stop_q
                                                                        : diff9[FREQ_W-1:0];
          end
          state_nxt = DWELL;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_nxt     = IDLE;
      freq_nxt      = freq_word;
      dwell_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: stimulus pushes expected freq words / done tokens,
// a negedge monitor pops and compares on every new dwell frequency and every done pulse.
module tb_freq_sweep_ctrl;

  localparam int DONE_TOK = 256;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_loop;
  logic [7:0]  cfg_start_freq, cfg_stop_freq, cfg_step;
  logic [15:0] cfg_dwell, cfg_div;
  logic [7:0]  freq_word;
  logic        sample_tick, busy, done;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  bit tick_chk = 1'b0;
  int exp_ticks = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  freq_sweep_ctrl #(.DWELL_W(16), .DIV_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_div        (cfg_div),
    .cfg_loop       (cfg_loop),
    .freq_word      (freq_word),
    .sample_tick    (sample_tick),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: new frequency = busy rising or freq_word changing while busy.
  initial begin
    bit prev_busy = 1'b0;
    int prev_freq = 0;
    int seg_ticks = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && (!prev_busy || int'(freq_word) != prev_freq)) begin
          if (prev_busy && tick_chk) check("dwell_ticks", seg_ticks, exp_ticks);
          if (exp_q.size() == 0) check("unexpected_freq", int'(freq_word), -1);
          else check("freq_word", int'(freq_word), exp_q.pop_front());
          seg_ticks = int'(sample_tick);
        end else if (busy) begin
          seg_ticks += int'(sample_tick);
        end
        if (!busy && prev_busy && tick_chk) check("dwell_ticks_last", seg_ticks, exp_ticks);
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) check("unexpected_done", DONE_TOK, -1);
          else check("done_pulse", DONE_TOK + int'(busy), exp_q.pop_front());
        end
      end
      prev_busy = busy;
      prev_freq = int'(freq_word);
    end
  end

  task automatic set_div(input logic [15:0] d);
    @(posedge clk); #1 cfg_div = d;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                     input logic [15:0] dw, input logic lp);
    @(posedge clk); #1;
    cfg_start_freq = a; cfg_stop_freq = b; cfg_step = s; cfg_dwell = dw; cfg_loop = lp;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) return;
    end
    check({name, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_drained(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    check({name, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_loop = 1'b0;
    cfg_start_freq = 8'd0; cfg_stop_freq = 8'd0; cfg_step = 8'd0;
    cfg_dwell = 16'd1; cfg_div = 16'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq", int'(freq_word), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(sample_tick), 0);
    rst = 1'b0;

    // Divider period with div=2 is 3 clocks.
    n = 0;
    while (!sample_tick && n < 10) begin @(posedge clk); #1; n++; end
    check("tick_seen", int'(sample_tick), 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sample_tick && n < 10);
    check("tick_period_div2", n, 3);
    set_div(16'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; n += int'(sample_tick); end
    check("tick_every_clock", n, 3);

    // Basic up sweep, 2 ticks per word.
    set_div(16'd3);
    tick_chk = 1'b1; exp_ticks = 2;
    exp_q = '{10, 20, 30, 40, DONE_TOK};
    d0 = done_seen;
    run(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
    wait_idle("up_sweep", 500);
    tick_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("up_done_once", done_seen - d0, 1);
    check("up_busy_low", int'(busy), 0);
    check("idle_hold_freq", int'(freq_word), 40);

    // Down sweep clamped at stop.
    set_div(16'd1);
    exp_q = '{200, 196, 192, 190, DONE_TOK};
    run(8'd200, 8'd190, 8'd4, 16'd1, 1'b0);
    wait_idle("down_sweep", 500);

    // Up sweep clamped at 255 without wrap.
    exp_q = '{250, 255, DONE_TOK};
    run(8'd250, 8'd255, 8'd10, 16'd1, 1'b0);
    wait_idle("no_wrap", 500);

    // Looping sweep, then abort.
    set_div(16'd3);
    exp_q = '{5, 6, 7, 5, 6};
    d0 = done_seen;
    run(8'd5, 8'd7, 8'd1, 16'd1, 1'b1);
    wait_drained("loop", 500);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_freq_held", int'(freq_word), 6);
    check("abort_done", int'(done), 0);
    repeat (10) @(posedge clk);
    #1;
    check("loop_no_done", done_seen - d0, 0);

    // step=0, dwell=0, start==stop; a second start while busy must be ignored.
    set_div(16'd0);
    exp_q = '{9, DONE_TOK};
    @(posedge clk); #1;
    cfg_start_freq = 8'd9; cfg_stop_freq = 8'd9; cfg_step = 8'd0; cfg_dwell = 16'd0;
    cfg_loop = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cfg_start_freq = 8'd50; cfg_stop_freq = 8'd60;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("single_word", 100);
    check("single_word_hold", int'(freq_word), 9);

    // Reset mid-dwell, then a fresh sweep.
    set_div(16'd3);
    exp_q = '{100};
    d0 = done_seen;
    run(8'd100, 8'd200, 8'd10, 16'd4, 1'b0);
    wait_drained("pre_reset", 200);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_freq", int'(freq_word), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done_seen - d0, 0);
    exp_q = '{1, 3, DONE_TOK};
    run(8'd1, 8'd3, 8'd2, 16'd1, 1'b0);
    wait_idle("post_reset", 500);
    check("post_reset_done", done_seen - d0, 1);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
